// File: rtl/comp_2bit.sv
// Registered unsigned magnitude comparator.
// One-hot eq/gt/lt flags plus a single-cycle valid strobe.
module comp_2bit #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             in_valid,
    output logic             a_eq_b,
    output logic             a_gt_b,
    output logic             a_lt_b,
    output logic             out_valid
);

    typedef struct packed {
        logic eq;
        logic gt;
        logic lt;
    } flags_t;

    flags_t cmp_d;
    flags_t cmp_q;
    logic   vld_q;

    always_comb begin
        cmp_d = '0;
        unique case (1'b1)
            (a == b): cmp_d.eq = 1'b1;
            (a > b):  cmp_d.gt = 1'b1;
            default:  cmp_d.lt = 1'b1;
        endcase
    end

    // Flags hold across idle cycles; only the strobe drops.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmp_q <= '0;
            vld_q <= 1'b0;
        end else begin
            vld_q <= in_valid;
            if (in_valid) begin
                cmp_q <= cmp_d;
            end
        end
    end

    assign a_eq_b    = cmp_q.eq;
    assign a_gt_b    = cmp_q.gt;
    assign a_lt_b    = cmp_q.lt;
    assign out_valid = vld_q;

endmodule

// File: tb/tb_comp_2bit.sv
// Scoreboard bench for comp_2bit.
// Driver queues expected outputs; monitor checks them each cycle.
module tb_comp_2bit;

    localparam int WIDTH = 2;

    typedef struct packed {
        logic v;
        logic eq;
        logic gt;
        logic lt;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_valid = 1'b0;
    logic             a_eq_b;
    logic             a_gt_b;
    logic             a_lt_b;
    logic             out_valid;

    exp_t  exp_q[$];
    string tag_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;
    exp_t  held = '0;

    always #50 clk = ~clk;

    comp_2bit #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .a         (a),
        .b         (b),
        .in_valid  (in_valid),
        .a_eq_b    (a_eq_b),
        .a_gt_b    (a_gt_b),
        .a_lt_b    (a_lt_b),
        .out_valid (out_valid)
    );

    // Hand-given expectation: ex is {eq,gt,lt} for an accepted pair.
    task automatic step(input logic r, input logic v,
                        input logic [WIDTH-1:0] av,
                        input logic [WIDTH-1:0] bv,
                        input logic [2:0] ex, input string tag);
        exp_t e;
        @(negedge clk);
        rst      = r;
        in_valid = v;
        a        = av;
        b        = bv;
        @(posedge clk);
        #1;
        if (r) begin
            held = '0;
            e    = '0;
        end else if (v) begin
            held = {1'b0, ex};
            e    = {1'b1, ex};
        end else begin
            e = {1'b0, held.eq, held.gt, held.lt};
        end
        exp_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t  e;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            n_cmp++;
            if ({out_valid, a_eq_b, a_gt_b, a_lt_b} !== e) begin
                n_bad++;
                $display("FAIL %s: got v=%b eq=%b gt=%b lt=%b want v=%b eq=%b gt=%b lt=%b",
                         t, out_valid, a_eq_b, a_gt_b, a_lt_b,
                         e.v, e.eq, e.gt, e.lt);
            end
        end
    end

    localparam logic [2:0] EQ = 3'b100;
    localparam logic [2:0] GT = 3'b010;
    localparam logic [2:0] LT = 3'b001;
    localparam logic [2:0] NO = 3'b000;

    // Sweep order from a=3,b=0: b counts, a steps when b wraps.
    localparam logic [2:0] SWEEP [16] = '{
        GT, GT, GT, EQ,
        EQ, LT, LT, LT,
        GT, EQ, LT, LT,
        GT, GT, EQ, LT
    };

    initial begin
        logic [WIDTH-1:0] sa;
        logic [WIDTH-1:0] sb;
        int               guard;

        step(1, 1, 3, 0, NO, "reset0");
        step(1, 1, 3, 0, NO, "reset1");
        step(0, 1, 3, 0, GT, "first");

        sa = 3;
        sb = 0;
        for (int i = 0; i < 16; i++) begin
            step(0, 1, sa, sb, SWEEP[i], $sformatf("sweep%0d_%0d%0d", i, sa, sb));
            sb = sb + 1'b1;
            if (sb == 0) sa = sa + 1'b1;
        end

        step(0, 1, 0, 3, LT, "bnd_0_3");
        step(0, 1, 3, 0, GT, "bnd_3_0");
        step(0, 1, 3, 3, EQ, "bnd_3_3");

        step(0, 1, 2, 1, GT, "hold_acc");
        step(0, 0, 0, 3, NO, "hold1");
        step(0, 0, 0, 3, NO, "hold2");
        step(0, 0, 0, 3, NO, "hold3");

        step(0, 1, 1, 1, EQ, "b2b_eq");
        step(0, 1, 2, 1, GT, "b2b_gt");
        step(0, 1, 0, 1, LT, "b2b_lt");

        step(0, 1, 1, 1, EQ, "mid_pre");
        step(1, 1, 2, 1, NO, "mid_rst");
        step(0, 1, 0, 1, LT, "mid_lt");
        step(0, 1, 3, 3, EQ, "mid_eq");
        step(0, 0, 2, 0, NO, "tail_idle");

        in_valid = 1'b0;
        guard = 0;
        while (exp_q.size() > 0 && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        if (exp_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
